// File: rtl/mem_arbiter.sv
// Round-robin arbiter between instruction fetch and data access onto a single-ported,
// variable-latency RAM, with per-access timeout and halt-aware fetch gating.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                halt,
  input  logic                iREN,
  input  logic [ADDR_W-1:0]   iaddr,
  input  logic                dREN,
  input  logic                dWEN,
  input  logic [ADDR_W-1:0]   daddr,
  input  logic [DATA_W-1:0]   dstore,
  input  logic [DATA_W/8-1:0] dben,
  output logic                ihit,
  output logic [DATA_W-1:0]   iload,
  output logic                dhit,
  output logic [DATA_W-1:0]   dload,
  output logic                err,
  output logic                busy,
  output logic                ramREN,
  output logic                ramWEN,
  output logic [ADDR_W-1:0]   ramaddr,
  output logic [DATA_W-1:0]   ramstore,
  output logic [DATA_W/8-1:0] ramben,
  input  logic                ramready,
  input  logic [DATA_W-1:0]   ramload
);

  localparam int BEN_W = DATA_W / 8;
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, IACC, DACC, RESP} state_t;
  typedef enum logic {GRANT_INSTR, GRANT_DATA} side_t;

  state_t              state_q, state_d;
  side_t               last_grant_q, last_grant_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ihit_q, ihit_d, dhit_q, dhit_d, err_q, err_d, busy_q, busy_d;
  logic [DATA_W-1:0]   iload_q, iload_d, dload_q, dload_d;
  logic                ram_ren_q, ram_ren_d, ram_wen_q, ram_wen_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_store_q, ram_store_d;
  logic [BEN_W-1:0]    ram_ben_q, ram_ben_d;
  logic                d_req, i_req, pick_data, timed_out;

  // The RAM-side registers double as the captured request, so nothing is re-sampled after grant.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    ihit_d       = 1'b0;
    dhit_d       = 1'b0;
    err_d        = 1'b0;
    iload_d      = iload_q;
    dload_d      = dload_q;
    ram_ren_d    = ram_ren_q;
    ram_wen_d    = ram_wen_q;
    ram_addr_d   = ram_addr_q;
    ram_store_d  = ram_store_q;
    ram_ben_d    = ram_ben_q;

    d_req     = dREN | dWEN;
    i_req     = iREN & ~halt;
    pick_data = d_req & (~i_req | (last_grant_q == GRANT_INSTR));
    timed_out = (cnt_q == CNT_LAST);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pick_data) begin
          state_d      = DACC;
          last_grant_d = GRANT_DATA;
          ram_addr_d   = daddr;
          if (dWEN) begin
            ram_wen_d   = 1'b1;
            ram_store_d = dstore;
            ram_ben_d   = dben;
          end else begin
            ram_ren_d   = 1'b1;
            ram_store_d = '0;
            ram_ben_d   = '1;
          end
        end else if (i_req) begin
          state_d      = IACC;
          last_grant_d = GRANT_INSTR;
          ram_addr_d   = iaddr;
          ram_ren_d    = 1'b1;
          ram_store_d  = '0;
          ram_ben_d    = '1;
        end
      end
      IACC, DACC: begin
        if (ramready || timed_out) begin
          state_d   = RESP;
          cnt_d     = '0;
          ram_ren_d = 1'b0;
          ram_wen_d = 1'b0;
          err_d     = ~ramready;
          if (state_q == IACC) begin
            ihit_d  = 1'b1;
            iload_d = ramready ? ramload : '0;
          end else begin
            dhit_d = 1'b1;
            if (!ramready)      dload_d = '0;
            else if (!ram_wen_q) dload_d = ramload;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (RST) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_INSTR;
      cnt_q        <= '0;
      ihit_q       <= 1'b0;
      dhit_q       <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      iload_q      <= '0;
      dload_q      <= '0;
      ram_ren_q    <= 1'b0;
      ram_wen_q    <= 1'b0;
      ram_addr_q   <= '0;
      ram_store_q  <= '0;
      ram_ben_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      ihit_q       <= ihit_d;
      dhit_q       <= dhit_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      iload_q      <= iload_d;
      dload_q      <= dload_d;
      ram_ren_q    <= ram_ren_d;
      ram_wen_q    <= ram_wen_d;
      ram_addr_q   <= ram_addr_d;
      ram_store_q  <= ram_store_d;
      ram_ben_q    <= ram_ben_d;
    end
  end

  assign ihit     = ihit_q;
  assign iload    = iload_q;
  assign dhit     = dhit_q;
  assign dload    = dload_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign ramREN   = ram_ren_q;
  assign ramWEN   = ram_wen_q;
  assign ramaddr  = ram_addr_q;
  assign ramstore = ram_store_q;
  assign ramben   = ram_ben_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Responder for the instruction-fetch and data-access requests (iREN, dREN, dWEN) that the CPU control path raises.
- Arbitrates both request streams onto a single-ported RAM with variable latency.
- Returns a one-cycle ihit or dhit together with the load data.
- Sits between the datapath and the RAM model. Uses round-robin arbitration, a per-transaction timeout, and halt-aware instruction gating.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits; byte-enable width is DATA_W/8.
- TIMEOUT, 16, maximum number of cycles waiting for ramready before the transaction is aborted with an error (must be >= 2).

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- halt  in  1  CPU halted; blocks new instruction grants.
- iREN  in  1  instruction read request; held until ihit.
- iaddr  in  ADDR_W  instruction address.
- dREN  in  1  data read request; held until dhit.
- dWEN  in  1  data write request; held until dhit.
- daddr  in  ADDR_W  data address.
- dstore  in  DATA_W  store data.
- dben  in  DATA_W/8  store byte enables (1111 word, 0011 half, 0001 byte, pre-shifted by requester).
- ihit  out  1  one-cycle instruction completion pulse.
- iload  out  DATA_W  instruction word; valid while ihit=1, held afterwards.
- dhit  out  1  one-cycle data completion pulse.
- dload  out  DATA_W  load data; valid while dhit=1, held afterwards.
- err  out  1  high with the hit pulse when the transaction timed out.
- busy  out  1  high in any state other than IDLE.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramben  out  DATA_W/8  RAM byte enables.
- ramready  in  1  RAM completes the current access this cycle.
- ramload  in  DATA_W  RAM read data; valid while ramready=1.

Behaviour:

Reset:
- RST=1 at a rising edge forces state IDLE.
- All outputs go to 0; timeout counter clears.
- last_grant is set to INSTR, so data wins the first tie.
- This applies mid-transaction too: the RAM strobes drop the next cycle and no hit is issued for the aborted transaction.

State machine (IDLE, IACC, DACC, RESP), all outputs registered:

IDLE:
- Compute d_req = dREN|dWEN and i_req = iREN & !halt.
- Both pending: grant the side opposite to last_grant.
- One pending: grant it.
- On grant: capture the address (plus dstore, dben and write flag for data), go to IACC or DACC, update last_grant.

IACC / DACC:
- Drive the captured address on ramaddr.
- DACC write: ramWEN=1, ramstore, ramben.
- DACC read and IACC: ramREN=1, ramben=all ones.
- Timeout counter increments each cycle in the state.
- If ramready=1: latch ramload (reads only) into iload or dload, go RESP with err=0.
- If the counter reaches TIMEOUT-1 without ramready: go RESP with err=1; the load register is set to all zeros.
- ramready takes precedence over timeout in the same cycle.

RESP:
- ramREN and ramWEN are 0.
- Exactly one of ihit/dhit is 1 for one cycle, err as latched.
- Next state IDLE; counter clears.

Latency and ordering:
- Request seen in IDLE at cycle N, ramready at N+1: hit at N+2.
- Each additional ready-wait cycle adds one.
- Minimum spacing between hits is 3 cycles: the RESP→IDLE bubble is mandatory.

Request and signal rules:
- dREN and dWEN both high: treated as a write.
- Requests dropped mid-transaction do not cancel it; the hit still pulses.
- Inputs are sampled only in IDLE; changes to iaddr/daddr/dstore after grant are ignored.
- halt rising during IACC: the fetch completes normally, and no further instruction grants are made while halt=1.
- Data requests are always served regardless of halt.
- ramready outside IACC/DACC is ignored.
- iload and dload hold their last value until overwritten; err is valid only with a hit.

Test Plan:
1. Reset then iREN=1, iaddr=0x0000_0040, ramready=1 on the first IACC cycle, ramload=0x2408_0005 → ihit=1 exactly 2 cycles after grant, iload=0x2408_0005, ramREN=1 for one cycle, err=0.
2. dWEN=1, daddr=0x80, dstore=0x0000_00AB, dben=0001, ramready after 3 wait cycles → ramWEN=1 with ramben=0001 for 4 cycles, ramREN=0, dhit pulse one cycle later, no ihit.
3. iREN and dREN held continuously from reset, ramready always 1 → grants alternate D,I,D,I; hits every 3 cycles; data first.
4. halt=1 with iREN=1 held and a dREN request → only dhit occurs; ihit never asserts over 50 cycles.
5. TIMEOUT=16, dREN=1, ramready never asserted → dhit=1 with err=1 and dload=0 at grant+17; busy falls the cycle after.
6. RST=1 during DACC wait (cycle 2 of the access) → next cycle ramREN=ramWEN=0, state IDLE, no dhit. A subsequent request with iREN and dREN both high grants data first.
